// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - display geometry and rectangle controller state type
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int W_OF_REC   = 48;
  localparam int H_OF_REC   = 48;

  typedef enum logic [1:0] {
    FOLLOW = 2'd0,
    FALL   = 2'd1,
    BOUNCE = 2'd2,
    LANDED = 2'd3
  } rect_state_t;

  function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - rising-edge pulse from a level synchronous to clk
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_pulse
);

  logic r_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_d <= 1'b0;
    else        r_d <= i_d;
  end

  assign o_pulse = i_d & ~r_d;

endmodule

// File: rtl/draw_rect_ctl.sv
// rtl/draw_rect_ctl.sv - rectangle follows mouse, falls under gravity on click
// Optional bounce on impact: define DRAW_RECT_CTL_BOUNCE_EN.
module draw_rect_ctl
  import vga_pkg::*;
#(
  parameter int GRAV  = 1,
  parameter int VMAX  = 40,
  parameter int VSTOP = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        busy
);

  localparam logic [11:0] XMAX   = 12'(HOR_PIXELS - 1 - W_OF_REC);
  localparam logic [11:0] YMAX   = 12'(VER_PIXELS - 1 - H_OF_REC);
  localparam logic [11:0] GRAV_V = 12'(GRAV);
  localparam logic [11:0] VMAX_V = 12'(VMAX);
`ifdef DRAW_RECT_CTL_BOUNCE_EN
  localparam logic [11:0] VSTOP_V = 12'(VSTOP);
`endif

  rect_state_t r_state, w_state_nx;
  logic [11:0] r_xpos, r_ypos, r_vel;
  logic        r_busy;
  logic [11:0] w_xpos_nx, w_ypos_nx, w_vel_nx;
  logic        w_tick, w_click;
  logic [12:0] w_sum, w_vinc;
  logic [11:0] w_vel_sat;

  edge_det u_tick_det (.clk(clk), .rst_n(rst), .i_d(vblnk),      .o_pulse(w_tick));
  edge_det u_click_det(.clk(clk), .rst_n(rst), .i_d(mouse_left), .o_pulse(w_click));

  assign w_sum     = {1'b0, r_ypos} + {1'b0, r_vel};
  assign w_vinc    = {1'b0, r_vel} + {1'b0, GRAV_V};
  assign w_vel_sat = (w_vinc >= {1'b0, VMAX_V}) ? VMAX_V : w_vinc[11:0];

  always_comb begin
    w_state_nx = r_state;
    w_xpos_nx  = r_xpos;
    w_ypos_nx  = r_ypos;
    w_vel_nx   = r_vel;
    case (r_state)
      FOLLOW: begin
        if (w_click) begin
          w_state_nx = FALL;
          w_vel_nx   = 12'd0;
        end else begin
          w_xpos_nx = clamp12(mouse_xpos, XMAX);
          w_ypos_nx = clamp12(mouse_ypos, YMAX);
        end
      end
      FALL: begin
        if (w_tick) begin
          if (w_sum >= {1'b0, YMAX}) begin
            w_ypos_nx = YMAX;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
            if (r_vel >= VSTOP_V) begin
              w_state_nx = BOUNCE;
              w_vel_nx   = r_vel - (r_vel >> 2);
            end else begin
              w_state_nx = LANDED;
              w_vel_nx   = 12'd0;
            end
`else
            w_state_nx = LANDED;
            w_vel_nx   = 12'd0;
`endif
          end else begin
            w_ypos_nx = w_sum[11:0];
            w_vel_nx  = w_vel_sat;
          end
        end
      end
      BOUNCE: begin
`ifdef DRAW_RECT_CTL_BOUNCE_EN
        if (w_tick) begin
          if (r_vel <= GRAV_V) begin
            w_state_nx = FALL;
            w_vel_nx   = 12'd0;
          end else begin
            w_ypos_nx = (r_ypos > r_vel) ? r_ypos - r_vel : 12'd0;
            w_vel_nx  = r_vel - GRAV_V;
          end
        end
`else
        // Unreachable without bounce support; recover to tracking.
        w_state_nx = FOLLOW;
        w_vel_nx   = 12'd0;
`endif
      end
      LANDED: begin
        if (w_click) w_state_nx = FOLLOW;
      end
      default: w_state_nx = FOLLOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FOLLOW;
      r_xpos  <= 12'd0;
      r_ypos  <= 12'd0;
      r_vel   <= 12'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_xpos  <= w_xpos_nx;
      r_ypos  <= w_ypos_nx;
      r_vel   <= w_vel_nx;
      r_busy  <= (w_state_nx == FALL) || (w_state_nx == BOUNCE);
    end
  end

  assign xpos = r_xpos;
  assign ypos = r_ypos;
  assign busy = r_busy;

endmodule
